// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_e;

    // PS/2 uses odd parity over data plus parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is always visible on o_data.
module sync_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = ps2_event_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  T                         i_data,
    output T                         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_push_ok = i_push & (~o_full | i_pop);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: pin sync, frame deserialiser with timeout,
// E0/F0 prefix folding and a show-ahead event FIFO.
module ps2_keyboard_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 12500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    input  logic                          rdEn,
    output logic                          keyValid,
    output logic [7:0]                    keyCode,
    output logic                          keyExtended,
    output logic                          keyRelease,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          overflow,
    output logic                          parityErr,
    output logic                          frameErr
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    ps2_rx_state_e          r_state,   w_state_nxt;
    logic [2:0]             r_bit_cnt, w_bit_nxt;
    logic [7:0]             r_shift,   w_shift_nxt;
    logic                   r_par,     w_par_nxt;
    logic [TO_W-1:0]        r_to_cnt,  w_to_nxt;
    logic                   r_ext,     w_ext_nxt;
    logic                   r_rel,     w_rel_nxt;
    logic                   r_perr,    w_perr;
    logic                   r_ferr,    w_ferr;
    logic                   r_overflow;
    logic                   w_clk;
    logic                   w_dat;
    logic                   w_fall;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    ps2_event_t             w_event;
    ps2_event_t             w_head;

    assign w_clk  = r_clk_sync[SYNC_STAGES-1];
    assign w_dat  = r_dat_sync[SYNC_STAGES-1];
    assign w_fall = r_clk_prev & ~w_clk;

    // Synchronisers idle high, matching an undriven PS/2 bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DAT};
            r_clk_prev <= w_clk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_to_cnt   <= w_to_nxt;
            r_ext      <= w_ext_nxt;
            r_rel      <= w_rel_nxt;
            r_perr     <= w_perr;
            r_ferr     <= w_ferr;
            r_overflow <= r_overflow | (w_push & w_full & ~w_pop);
        end
    end

    // Deframer, timeout and prefix folding.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_to_nxt    = '0;
        w_ext_nxt   = r_ext;
        w_rel_nxt   = r_rel;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;

        if (r_state != IDLE && !w_fall) begin
            w_to_nxt = r_to_cnt + TO_W'(1);
        end

        case (r_state)
            IDLE: begin
                if (w_fall && !w_dat) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shift_nxt = {w_dat, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_par_nxt   = w_dat;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    if (!w_dat) begin
                        w_ferr = 1'b1;
                    end else if (!ps2_parity_ok(r_shift, r_par)) begin
                        w_perr = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (r_state != IDLE && !w_fall && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = IDLE;
            w_to_nxt    = '0;
            w_ferr      = 1'b1;
        end

        if (w_perr || w_ferr) begin
            w_ext_nxt = 1'b0;
            w_rel_nxt = 1'b0;
        end

        if (w_accept) begin
            if (r_shift == PS2_PREFIX_EXT) begin
                w_ext_nxt = 1'b1;
            end else if (r_shift == PS2_PREFIX_REL) begin
                w_rel_nxt = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_ext_nxt = 1'b0;
                w_rel_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        w_event      = '0;
        w_event.ext  = r_ext;
        w_event.rel  = r_rel;
        w_event.code = r_shift;
    end

    assign w_pop = rdEn & ~w_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (ps2_event_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_event),
        .o_data  (w_head),
        .o_count (fifoCount),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign keyValid    = ~w_empty;
    assign keyCode     = w_head.code;
    assign keyExtended = w_head.ext;
    assign keyRelease  = w_head.rel;
    assign overflow    = r_overflow;
    assign parityErr   = r_perr;
    assign frameErr    = r_ferr;

endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// Directed bench for ps2_keyboard_rx_fifo: bit-banged PS/2 frames, immediate-assert checks.
module tb_ps2_keyboard_rx_fifo;

    localparam int unsigned FIFO_DEPTH     = 8;
    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned TIMEOUT_CYCLES = 12500;
    localparam int unsigned HALF           = 8;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic       rdEn    = 1'b0;
    logic       keyValid;
    logic [7:0] keyCode;
    logic       keyExtended;
    logic       keyRelease;
    logic [3:0] fifoCount;
    logic       overflow;
    logic       parityErr;
    logic       frameErr;

    int   n_checks = 0;
    int   n_err    = 0;
    int   perr_cnt = 0;
    int   ferr_cnt = 0;
    logic kv_before;
    logic kv_after;

    ps2_keyboard_rx_fifo #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .rdEn        (rdEn),
        .keyValid    (keyValid),
        .keyCode     (keyCode),
        .keyExtended (keyExtended),
        .keyRelease  (keyRelease),
        .fifoCount   (fifoCount),
        .overflow    (overflow),
        .parityErr   (parityErr),
        .frameErr    (frameErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parityErr) perr_cnt++;
        if (frameErr)  ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    function automatic logic [31:0] head();
        return 32'({keyExtended, keyRelease, keyCode});
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({keyValid, keyExtended, keyRelease, keyCode, fifoCount, overflow, parityErr, frameErr});
    endfunction

    // Sends the first n bits of a frame; data changes while PS2_CLK is high.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = f[i];
            repeat (HALF) @(negedge clk);
            PS2_CLK = 1'b0;
            repeat (HALF) @(negedge clk);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic send_key(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0, 1'b1), 11);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Full frame with keyValid sampled around the push cycle; optional pop on that cycle.
    task automatic send_tail(input logic [10:0] f, input logic pop);
        send_bits(f, 10);
        PS2_DAT = f[10];
        repeat (HALF) @(negedge clk);
        PS2_CLK = 1'b0;
        repeat (SYNC_STAGES) @(posedge clk);
        @(negedge clk);
        kv_before = keyValid;
        rdEn      = pop;
        @(negedge clk);
        rdEn      = 1'b0;
        kv_after  = keyValid;
        repeat (HALF) @(negedge clk);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop();
        rdEn = 1'b1;
        @(negedge clk);
        rdEn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: plain make code and its latency
        send_tail(mk_frame(8'h1C, 1'b0, 1'b1), 1'b0);
        chk("t1_valid_before_push", 32'(kv_before), 32'h0);
        chk("t1_valid_after_push", 32'(kv_after), 32'h1);
        chk("t1_head", head(), 32'h01C);
        pop();
        chk("t1_valid_after_pop", 32'(keyValid), 32'h0);

        // 2: E0 F0 75 folds into one event
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        chk("t2_count", 32'(fifoCount), 32'd1);
        chk("t2_head", head(), 32'h375);
        pop();

        // 3: parity error, then error clears a pending E0
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("t3_perr_pulses", 32'(perr_cnt), 32'd1);
        chk("t3_no_push", 32'(fifoCount), 32'd0);
        send_key(8'hE0);
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
        send_key(8'hF0);
        send_key(8'h1C);
        chk("t3_perr_pulses2", 32'(perr_cnt), 32'd2);
        chk("t3_count", 32'(fifoCount), 32'd1);
        chk("t3_head", head(), 32'h11C);
        pop();

        // 4: bad stop bit, then mid-frame timeout, then recovery
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("t4_stop_ferr", 32'(ferr_cnt), 32'd1);
        chk("t4_stop_no_push", 32'(fifoCount), 32'd0);
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 4);
        PS2_DAT = 1'b1;
        repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
        chk("t4_timeout_ferr", 32'(ferr_cnt), 32'd2);
        send_key(8'h29);
        chk("t4_recover_head", head(), 32'h029);
        chk("t4_recover_count", 32'(fifoCount), 32'd1);
        chk("t4_no_extra_ferr", 32'(ferr_cnt), 32'd2);
        pop();

        // 5: overflow by one, then drain in order
        for (int i = 0; i <= int'(FIFO_DEPTH); i++) begin
            send_key(8'h10 + 8'(i));
        end
        chk("t5_count_full", 32'(fifoCount), 32'(FIFO_DEPTH));
        chk("t5_overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            chk("t5_drain_head", head(), 32'h010 + 32'(i));
            pop();
        end
        chk("t5_empty", 32'(keyValid), 32'h0);
        chk("t5_overflow_sticky", 32'(overflow), 32'h1);

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_overflow_cleared", 32'(overflow), 32'h0);

        // 6: push and pop on the same cycle while full
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            send_key(8'h20 + 8'(i));
        end
        send_tail(mk_frame(8'h28, 1'b0, 1'b1), 1'b1);
        chk("t6_full_before", 32'(kv_before), 32'h1);
        chk("t6_count", 32'(fifoCount), 32'(FIFO_DEPTH));
        chk("t6_no_overflow", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_drain_head", head(), 32'h021 + 32'(i));
            pop();
        end
        chk("t6_count_after_drain", 32'(fifoCount), 32'd4);

        // Reset mid-frame discards everything, no error pulse
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5);
        rst = 1'b0;
        PS2_DAT = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", all_outs(), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_key(8'h29);
        chk("rst_mid_head", head(), 32'h029);
        chk("rst_mid_count", 32'(fifoCount), 32'd1);
        chk("rst_mid_no_ferr", 32'(ferr_cnt), 32'd2);
        chk("rst_mid_no_perr", 32'(perr_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
